// File: rtl/quant_pack_if.sv
// Handshake bundle for quant_pack: sample input stream, packed word
// output stream and outlier (escaped float32) stream.
interface quant_pack_if #(
  parameter int unsigned CNT_W = 32
);
  // Sample input stream
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_code;
  logic             in_ovf;
  logic             in_udf;
  logic [31:0]      in_raw;
  logic             in_last;
  // Packed word stream
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_last;
  logic             out_pad;
  // Outlier stream
  logic             esc_valid;
  logic             esc_ready;
  logic [31:0]      esc_data;
  logic [CNT_W-1:0] esc_count;

  // Producer of samples / consumer of both output streams
  modport master (
    output in_valid, in_code, in_ovf, in_udf, in_raw, in_last,
    output out_ready, esc_ready,
    input  in_ready,
    input  out_valid, out_data, out_last, out_pad,
    input  esc_valid, esc_data, esc_count
  );

  // The packer itself
  modport slave (
    input  in_valid, in_code, in_ovf, in_udf, in_raw, in_last,
    input  out_ready, esc_ready,
    output in_ready,
    output out_valid, out_data, out_last, out_pad,
    output esc_valid, esc_data, esc_count
  );
endinterface

// File: rtl/quant_pack.sv
// quant_pack: packs two 16-bit quantised codes per 32-bit word (earlier
// sample in the low half). Samples flagged overflow/underflow are written
// as ESC_CODE and their raw float32 is sent on a separate outlier stream.
module quant_pack #(
  parameter logic [15:0] ESC_CODE = 16'h8000,
  parameter logic [15:0] PAD_CODE = 16'h0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  quant_pack_if.slave  bus
);

  typedef enum logic {
    ST_LO,  // no half-word held
    ST_HI   // low half held, waiting for its partner
  } state_e;

  state_e             state_q,     state_d;
  logic [15:0]        lo_q,        lo_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_data_q,  out_data_d;
  logic               out_last_q,  out_last_d;
  logic               out_pad_q,   out_pad_d;
  logic               esc_valid_q, esc_valid_d;
  logic [31:0]        esc_data_q,  esc_data_d;
  logic [CNT_W-1:0]   esc_count_q, esc_count_d;

  logic               out_ok;
  logic               esc_ok;
  logic               accept;
  logic               flagged;
  logic [15:0]        code;

  // Input readiness depends only on the output registers and consumer readies
  always_comb begin
    out_ok  = !out_valid_q || bus.out_ready;
    esc_ok  = !esc_valid_q || bus.esc_ready;
    accept  = bus.in_valid && out_ok && esc_ok;
    flagged = bus.in_ovf || bus.in_udf;
    code    = flagged ? ESC_CODE : bus.in_code;
  end

  assign bus.in_ready  = out_ok && esc_ok;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_pad   = out_pad_q;
  assign bus.esc_valid = esc_valid_q;
  assign bus.esc_data  = esc_data_q;
  assign bus.esc_count = esc_count_q;

  // Next-state: drain on ready, then let an accepted sample reload the
  // output registers so accept and drain may share one edge.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_pad_d   = out_pad_q;
    esc_valid_d = esc_valid_q;
    esc_data_d  = esc_data_q;
    esc_count_d = esc_count_q;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    if (esc_valid_q && bus.esc_ready) esc_valid_d = 1'b0;

    if (accept) begin
      if (flagged) begin
        esc_valid_d = 1'b1;
        esc_data_d  = bus.in_raw;
        if (esc_count_q != '1) esc_count_d = esc_count_q + 1'b1;
      end

      unique case (state_q)
        ST_LO: begin
          if (bus.in_last) begin
            out_valid_d = 1'b1;
            out_data_d  = {PAD_CODE, code};
            out_last_d  = 1'b1;
            out_pad_d   = 1'b1;
          end else begin
            lo_d    = code;
            state_d = ST_HI;
          end
        end
        ST_HI: begin
          out_valid_d = 1'b1;
          out_data_d  = {code, lo_q};
          out_last_d  = bus.in_last;
          out_pad_d   = 1'b0;
          state_d     = ST_LO;
        end
        default: state_d = ST_LO;
      endcase
    end
  end

  // State and registered outputs; reset discards any partial word or outlier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LO;
      lo_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_pad_q   <= 1'b0;
      esc_valid_q <= 1'b0;
      esc_data_q  <= '0;
      esc_count_q <= '0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_pad_q   <= out_pad_d;
      esc_valid_q <= esc_valid_d;
      esc_data_q  <= esc_data_d;
      esc_count_q <= esc_count_d;
    end
  end

endmodule

// File: tb/tb_quant_pack.sv
// Scoreboard bench for quant_pack: the driver pushes expected words and
// outliers computed from the packing rules; a monitor pops and compares.
module tb_quant_pack;

  logic clk;
  logic rst_n;

  quant_pack_if #(.CNT_W(32)) bus ();

  quant_pack #(
    .ESC_CODE (16'h8000),
    .PAD_CODE (16'h0000),
    .CNT_W    (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        pad;
  } word_t;

  word_t       exp_out[$];
  logic [31:0] exp_esc[$];

  // reference model state
  bit          m_has_lo;
  logic [15:0] m_lo;
  logic [31:0] m_count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] last_word;
  logic [31:0] last_esc;

  // ready modes: 0 = both always ready, 1 = random, 2 = manual
  int unsigned rdy_mode = 0;
  logic        man_out_rdy = 1'b1;
  logic        man_esc_rdy = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of one accepted sample
  task automatic model_accept(input logic [15:0] c, input logic ovf, input logic udf,
                              input logic [31:0] raw, input logic last);
    logic [15:0] v;
    word_t w;
    v = (ovf || udf) ? 16'h8000 : c;
    if (ovf || udf) begin
      exp_esc.push_back(raw);
      if (m_count != 32'hffff_ffff) m_count = m_count + 32'd1;
    end
    if (!m_has_lo) begin
      if (last) begin
        w.data = {16'h0000, v}; w.last = 1'b1; w.pad = 1'b1;
        exp_out.push_back(w);
      end else begin
        m_lo = v; m_has_lo = 1'b1;
      end
    end else begin
      w.data = {v, m_lo}; w.last = last; w.pad = 1'b0;
      exp_out.push_back(w);
      m_has_lo = 1'b0;
    end
  endtask

  task automatic model_flush();
    m_has_lo = 1'b0;
    m_lo     = '0;
    m_count  = '0;
    exp_out.delete();
    exp_esc.delete();
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance
  task automatic send(input logic [15:0] c, input logic ovf, input logic udf,
                      input logic [31:0] raw, input logic last);
    int unsigned n;
    bit done;
    n = 0; done = 0;
    bus.in_valid = 1'b1;
    bus.in_code  = c;
    bus.in_ovf   = ovf;
    bus.in_udf   = udf;
    bus.in_raw   = raw;
    bus.in_last  = last;
    while (!done) begin
      #4;
      if (bus.in_ready) begin
        model_accept(c, ovf, udf, raw, last);
        done = 1;
      end else if (++n > 200) begin
        n_cmp++; n_err++;
        $display("FAIL send_timeout: in_ready stuck 0, required 1");
        done = 1;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  // Consumer readiness generator
  initial begin
    bus.out_ready = 1'b1;
    bus.esc_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: begin bus.out_ready = 1'b1; bus.esc_ready = 1'b1; end
        1: begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          bus.esc_ready = ($urandom_range(0, 2) != 0);
        end
        default: begin bus.out_ready = man_out_rdy; bus.esc_ready = man_esc_rdy; end
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer, checks hold stability
  initial begin
    bit          hold_out, hold_esc;
    logic [33:0] sv_out;
    logic [31:0] sv_esc;
    word_t       e;
    hold_out = 0; hold_esc = 0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        hold_out = 0; hold_esc = 0;
      end else begin
        if (hold_out) begin
          chk("out_hold_valid", 64'(bus.out_valid), 64'd1);
          chk("out_hold_data", 64'({bus.out_data, bus.out_last, bus.out_pad}), 64'(sv_out));
        end
        if (hold_esc) begin
          chk("esc_hold_valid", 64'(bus.esc_valid), 64'd1);
          chk("esc_hold_data", 64'(bus.esc_data), 64'(sv_esc));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_out.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL out_unexpected: got word %h, required none", bus.out_data);
          end else begin
            e = exp_out.pop_front();
            chk("out_word", 64'({bus.out_data, bus.out_last, bus.out_pad}),
                64'({e.data, e.last, e.pad}));
            last_word = bus.out_data;
          end
        end
        if (bus.esc_valid && bus.esc_ready) begin
          if (exp_esc.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL esc_unexpected: got %h, required none", bus.esc_data);
          end else begin
            chk("esc_beat", 64'(bus.esc_data), 64'(exp_esc.pop_front()));
            last_esc = bus.esc_data;
          end
        end
        chk("esc_count", 64'(bus.esc_count), 64'(m_count));
        hold_out = bus.out_valid && !bus.out_ready;
        sv_out   = {bus.out_data, bus.out_last, bus.out_pad};
        hold_esc = bus.esc_valid && !bus.esc_ready;
        sv_esc   = bus.esc_data;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    model_flush();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Stimulus
  initial begin
    bit ovf, udf, lst;
    int unsigned waited;
    bus.in_valid = 1'b0;
    bus.in_code  = '0;
    bus.in_ovf   = 1'b0;
    bus.in_udf   = 1'b0;
    bus.in_raw   = '0;
    bus.in_last  = 1'b0;
    last_word    = '0;
    last_esc     = '0;
    model_flush();
    rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_esc_valid", 64'(bus.esc_valid), 64'd0);
    chk("rst_esc_count", 64'(bus.esc_count), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

    // two plain codes pack into one word one cycle after the second accept
    send(16'h0001, 0, 0, 32'h0, 0);
    chk("t1_no_word_yet", 64'(bus.out_valid), 64'd0);
    send(16'h0002, 0, 0, 32'h0, 0);
    #1;
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_data", 64'(bus.out_data), 64'h0002_0001);
    chk("t1_last_pad", 64'({bus.out_last, bus.out_pad}), 64'd0);
    @(negedge clk);

    // overflow sample escapes; its raw float goes out the outlier stream
    send(16'h1234, 1, 0, 32'h4700_0000, 0);
    #1;
    chk("t2_esc_valid", 64'(bus.esc_valid), 64'd1);
    chk("t2_esc_data", 64'(bus.esc_data), 64'h4700_0000);
    chk("t2_esc_count", 64'(bus.esc_count), 64'd1);
    @(negedge clk);
    send(16'h0003, 0, 0, 32'h0, 0);
    #1;
    chk("t2_data", 64'(bus.out_data), 64'h0003_8000);
    @(negedge clk);

    // two escapes in a row, counted from a fresh reset
    do_reset();
    send(16'h0101, 0, 1, 32'hc700_0100, 0);
    send(16'h0202, 1, 0, 32'h4700_0000, 0);
    #1;
    chk("t3_data", 64'(bus.out_data), 64'h8000_8000);
    chk("t3_esc_count", 64'(bus.esc_count), 64'd2);
    @(negedge clk);
    @(negedge clk);
    chk("t3_last_esc", 64'(last_esc), 64'h4700_0000);

    // single last sample in LO gives a padded word
    send(16'h0005, 0, 0, 32'h0, 1);
    #1;
    chk("t4_data", 64'(bus.out_data), 64'h0000_0005);
    chk("t4_last_pad", 64'({bus.out_last, bus.out_pad}), 64'b11);
    @(negedge clk);

    // backpressure on the word stream for 10 cycles
    man_out_rdy = 1'b0; man_esc_rdy = 1'b1; rdy_mode = 2;
    @(negedge clk);
    send(16'h0011, 0, 0, 32'h0, 0);
    send(16'h0022, 0, 0, 32'h0, 0);
    repeat (10) begin
      #1;
      chk("t5_in_ready_stalled", 64'(bus.in_ready), 64'd0);
      chk("t5_data_stable", 64'(bus.out_data), 64'h0022_0011);
      @(negedge clk);
    end
    man_out_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("t5_drained", 64'(bus.out_valid), 64'd0);
    chk("t5_word", 64'(last_word), 64'h0022_0011);
    @(negedge clk);

    // reset in HI with an outlier held
    man_esc_rdy = 1'b0;
    @(negedge clk);
    send(16'h0009, 1, 0, 32'h3f80_0000, 0);
    #1;
    chk("t6_pre_esc_valid", 64'(bus.esc_valid), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    model_flush();
    #1;
    chk("t6_rst_esc_valid", 64'(bus.esc_valid), 64'd0);
    chk("t6_rst_esc_data", 64'(bus.esc_data), 64'd0);
    chk("t6_rst_esc_count", 64'(bus.esc_count), 64'd0);
    chk("t6_rst_out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0; man_esc_rdy = 1'b1;
    @(negedge clk);
    send(16'h0007, 0, 0, 32'h0, 0);
    send(16'h0008, 0, 0, 32'h0, 0);
    #1;
    chk("t6_data", 64'(bus.out_data), 64'h0008_0007);
    @(negedge clk);

    // randomized traffic with random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) @(negedge clk);
      ovf = ($urandom_range(0, 4) == 0);
      udf = ($urandom_range(0, 9) == 0);
      lst = (i == 399) || ($urandom_range(0, 6) == 0);
      send(16'($urandom), ovf, udf, $urandom, lst);
    end

    // drain everything
    rdy_mode = 0;
    waited = 0;
    while ((exp_out.size() != 0 || exp_esc.size() != 0) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    chk("drain_out_queue", 64'(exp_out.size()), 64'd0);
    chk("drain_esc_queue", 64'(exp_esc.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
